// File: rtl/azar_pkg.sv
// azar_seq shared types: FSM states, Gray-code helper, settle floor.
// Imported by every azar_seq RTL file.
package azar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    APPLY,
    WIN,
    EVAL,
    FIN
  } state_t;

  localparam int SETTLE_MIN = 4;

  function automatic logic [7:0] gray(
    input logic [7:0] i
  );
    return i ^ (i >> 1);
  endfunction

endpackage

// File: rtl/azar_seq_if.sv
// azar_seq bus: start/f toward the sequencer, stimulus and results back.
// master = bench/host side, slave = azar_seq.
interface azar_seq_if #(
  parameter int N  = 2,
  parameter int CW = 8
);
  import azar_pkg::*;

  logic          start;
  logic          f;
  logic [N-1:0]  x;
  logic          busy;
  logic          step_valid;
  logic          f_out;
  logic          hazard;
  logic [N-1:0]  hazard_x;
  logic [CW-1:0] hazard_count;
  logic          done;

  modport master (
    output start, f,
    input  x, busy, step_valid, f_out,
    input  hazard, hazard_x, hazard_count, done
  );

  modport slave (
    input  start, f,
    output x, busy, step_valid, f_out,
    output hazard, hazard_x, hazard_count, done
  );

endinterface

// File: rtl/azar_edge_cnt.sv
// 2-flop synchronizer for f plus saturating 2-bit transition counter.
// Ports: clk, reset, d (async f), clr, en (count enable) -> fs, tc.
module azar_edge_cnt
  import azar_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       d,
  input  logic       clr,
  input  logic       en,
  output logic       fs,
  output logic [1:0] tc
);

  logic s1;
  logic fs_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      fs   <= 1'b0;
      fs_d <= 1'b0;
      tc   <= 2'd0;
    end else begin
      s1   <= d;
      fs   <= s1;
      fs_d <= fs;
      if (clr)
        tc <= 2'd0;
      else if (en && (fs != fs_d) && (tc != 2'd3))
        tc <= tc + 2'd1;
    end
  end

endmodule

// File: rtl/azar_seq.sv
// Gray-code sweep sequencer + hazard detector for an N-input CUT.
// Ports: clk, reset (async high), bus (azar_seq_if.slave).
// Option: AZAR_SEQ_STOP_ON_HAZARD_EN ends the sweep at first hazard.
module azar_seq
  import azar_pkg::*;
#(
  parameter int N      = 2,
  parameter int SETTLE = 8,
  parameter int CW     = 8
) (
  input  logic       clk,
  input  logic       reset,
  azar_seq_if.slave  bus
);

  // Too-short windows cannot see a transition through the sync.
  localparam int SW =
    (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
  localparam int WW = $clog2(SW + 1);

  state_t        state, state_n;
  logic [WW-1:0] wc, wc_n;
  logic [N-1:0]  k, k_n;
  logic [N-1:0]  x_q, x_n;
  logic          f_prev, fp_n;
  logic [N-1:0]  hx_q, hx_n;
  logic [CW-1:0] hc_q, hc_n;

  logic          fs;
  logic [1:0]    tc;
  logic          clr;
  logic          en;
  logic          last;
  logic          expd;
  logic          hz;
  logic          stop;
  logic [N-1:0]  kp1;
  logic [7:0]    g8;

  azar_edge_cnt u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (bus.f),
    .clr   (clr),
    .en    (en),
    .fs    (fs),
    .tc    (tc)
  );

  assign last = (wc == WW'(SW - 1));
  assign kp1  = k + N'(1);
  assign g8   = gray(8'(kp1));
  assign expd = fs ^ f_prev;
  assign hz   = (tc > {1'b0, expd});

`ifdef AZAR_SEQ_STOP_ON_HAZARD_EN
  assign stop = hz;
`else
  assign stop = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      wc     <= '0;
      k      <= '0;
      x_q    <= '0;
      f_prev <= 1'b0;
      hx_q   <= '0;
      hc_q   <= '0;
    end else begin
      state  <= state_n;
      wc     <= wc_n;
      k      <= k_n;
      x_q    <= x_n;
      f_prev <= fp_n;
      hx_q   <= hx_n;
      hc_q   <= hc_n;
    end
  end

  always_comb begin
    state_n        = state;
    wc_n           = wc;
    k_n            = k;
    x_n            = x_q;
    fp_n           = f_prev;
    hx_n           = hx_q;
    hc_n           = hc_q;
    clr            = 1'b0;
    en             = 1'b0;
    bus.busy       = 1'b0;
    bus.step_valid = 1'b0;
    bus.f_out      = 1'b0;
    bus.hazard     = 1'b0;
    bus.done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = INIT;
          wc_n    = '0;
          x_n     = '0;
          hx_n    = '0;
          hc_n    = '0;
        end
      end
      INIT: begin
        bus.busy = 1'b1;
        if (last) begin
          fp_n    = fs;
          k_n     = '0;
          state_n = APPLY;
        end else begin
          wc_n = wc + WW'(1);
        end
      end
      APPLY: begin
        bus.busy = 1'b1;
        x_n      = g8[N-1:0];
        clr      = 1'b1;
        wc_n     = '0;
        state_n  = WIN;
      end
      WIN: begin
        bus.busy = 1'b1;
        en       = 1'b1;
        if (last)
          state_n = EVAL;
        else
          wc_n = wc + WW'(1);
      end
      EVAL: begin
        bus.busy       = 1'b1;
        bus.step_valid = 1'b1;
        bus.f_out      = fs;
        fp_n           = fs;
        if (hz) begin
          bus.hazard = 1'b1;
          hx_n       = x_q;
          if (hc_q != '1)
            hc_n = hc_q + CW'(1);
        end
        if ((k == '1) || stop) begin
          state_n = FIN;
        end else begin
          k_n     = kp1;
          state_n = APPLY;
        end
      end
      FIN: begin
        bus.done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.x            = x_q;
  assign bus.hazard_x     = hx_q;
  assign bus.hazard_count = hc_q;

endmodule

// File: tb/tb_azar_seq.sv
// Directed bench for azar_seq (N=2, SETTLE=8) with a CUT model
// that can inject static-1 and dynamic glitches.
module tb_azar_seq;

  localparam int N  = 2;
  localparam int ST = 8;
  localparam int CW = 8;
  // start cycle and done cycle both counted
  localparam int FULL = 1 + ST + 4 * (ST + 2) + 1;

  logic clk;
  logic reset;
  int   ncheck;
  int   nbad;
  int   mode;
  logic [1:0] xp;
  logic [1:0] xn;

  azar_seq_if #(.N(N), .CW(CW)) bus ();

  azar_seq #(
    .N      (N),
    .SETTLE (ST),
    .CW     (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    ncheck++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // CUT model: mode 0 f=x0&x1, mode 1 f=x1 with a
  // 2-cycle low pulse on 11->10, mode 2 f=x0&x1 with
  // 0-1-0-1 on 01->11.
  initial begin
    bus.f = 1'b0;
    xp = 2'b00;
    forever begin
      @(bus.x);
      xn = bus.x;
      #1;
      if (mode == 1 && xp == 2'b11 && xn == 2'b10) begin
        bus.f = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end else if (mode == 2 && xp == 2'b01 &&
                   xn == 2'b11) begin
        bus.f = 1'b1;
        @(posedge clk);
        #1 bus.f = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.f = (mode == 1) ? xn[1] : (xn[0] & xn[1]);
      xp = xn;
    end
  end

  task automatic sweep(
    input  int         pk,
    output int         nsv,
    output logic [3:0] fo,
    output logic [3:0] hz,
    output int         dcyc,
    output logic [1:0] dx,
    output logic [1:0] hx,
    output logic [7:0] hc
  );
    int cyc;
    nsv  = 0;
    fo   = '0;
    hz   = '0;
    dcyc = 0;
    dx   = 'x;
    hx   = 'x;
    hc   = 'x;
    @(negedge clk);
    bus.start = 1'b1;
    cyc = 1;
    while (dcyc == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.step_valid) begin
        if (nsv < 4) begin
          fo[nsv] = bus.f_out;
          hz[nsv] = bus.hazard;
        end
        nsv++;
      end
      if (bus.done) begin
        dcyc = cyc;
        dx   = bus.x;
        hx   = bus.hazard_x;
        hc   = bus.hazard_count;
      end
      bus.start = (cyc == pk);
    end
    bus.start = 1'b0;
    check("done_seen", 32'(dcyc != 0), 1);
  endtask

  int         nsv;
  logic [3:0] fo;
  logic [3:0] hz;
  int         dcyc;
  logic [1:0] dx;
  logic [1:0] hx;
  logic [7:0] hc;
  int         w;

  initial begin
    ncheck    = 0;
    nbad      = 0;
    mode      = 0;
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(bus.x), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_hc", 32'(bus.hazard_count), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // clean CUT
    sweep(0, nsv, fo, hz, dcyc, dx, hx, hc);
    check("cl_steps", 32'(nsv), 4);
    check("cl_fout", 32'(fo), 32'b0010);
    check("cl_hz", 32'(hz), 0);
    check("cl_hc", 32'(hc), 0);
    check("cl_cyc", 32'(dcyc), FULL);
    check("cl_x", 32'(dx), 0);
    check("cl_busy", 32'(bus.busy), 0);

    // start pulsed mid-window is ignored
    sweep(15, nsv, fo, hz, dcyc, dx, hx, hc);
    check("bs_steps", 32'(nsv), 4);
    check("bs_cyc", 32'(dcyc), FULL);
    repeat (3) @(negedge clk);
    check("bs_idle", 32'(bus.busy), 0);

    // static-1 hazard on 11->10
    mode = 1;
    sweep(0, nsv, fo, hz, dcyc, dx, hx, hc);
    check("st_fout", 32'(fo), 32'b0110);
    check("st_hz", 32'(hz), 32'b0100);
    check("st_hx", 32'(hx), 32'b10);
    check("st_hc", 32'(hc), 1);
`ifdef AZAR_SEQ_STOP_ON_HAZARD_EN
    check("st_steps", 32'(nsv), 3);
    check("st_x", 32'(dx), 32'b10);
    check("st_cyc", 32'(dcyc), 1 + ST + 3 * (ST + 2) + 1);
`else
    check("st_steps", 32'(nsv), 4);
    check("st_x", 32'(dx), 0);
    check("st_cyc", 32'(dcyc), FULL);
`endif

    // dynamic hazard on 01->11
    mode = 2;
    sweep(0, nsv, fo, hz, dcyc, dx, hx, hc);
    check("dy_hx", 32'(hx), 32'b11);
    check("dy_hc", 32'(hc), 1);
`ifdef AZAR_SEQ_STOP_ON_HAZARD_EN
    check("dy_steps", 32'(nsv), 2);
    check("dy_hz", 32'(hz), 32'b0010);
    check("dy_x", 32'(dx), 32'b11);
`else
    check("dy_steps", 32'(nsv), 4);
    check("dy_hz", 32'(hz), 32'b0010);
    check("dy_fout", 32'(fo), 32'b0010);
    check("dy_x", 32'(dx), 0);
`endif

    // reset during WIN of step 2
    mode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    w = 0;
    while (!bus.step_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("rm_sv_seen", 32'(bus.step_valid), 1);
    repeat (4) @(negedge clk);
    check("rm_pre_x", 32'(bus.x), 32'b11);
    check("rm_pre_busy", 32'(bus.busy), 1);
    #2 reset = 1'b1;
    #1;
    check("rm_x", 32'(bus.x), 0);
    check("rm_busy", 32'(bus.busy), 0);
    check("rm_sv", 32'(bus.step_valid), 0);
    check("rm_fout", 32'(bus.f_out), 0);
    check("rm_hz", 32'(bus.hazard), 0);
    check("rm_hx", 32'(bus.hazard_x), 0);
    check("rm_hc", 32'(bus.hazard_count), 0);
    check("rm_done", 32'(bus.done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    sweep(0, nsv, fo, hz, dcyc, dx, hx, hc);
    check("ra_steps", 32'(nsv), 4);
    check("ra_fout", 32'(fo), 32'b0010);
    check("ra_cyc", 32'(dcyc), FULL);
    check("ra_hc", 32'(hc), 0);

    $display("test done: total=%0d bad=%0d",
             ncheck, nbad);
    $finish;
  end

endmodule

// File: doc/azar_seq.md
Name: azar_seq

Overview:
- Gray-code stimulus sequencer and hazard (glitch) detector for a small N-input combinational circuit under test (CUT).
- Walks the CUT inputs through every single-bit transition and waits a settle window after each step.
- Counts output transitions in that window and flags static or dynamic hazards.
- Sits beside the combinational lesson circuits as the synthesizable counterpart of a hazard-hunting bench.

Parameters:
- N, 2, number of CUT inputs (1..8).
- SETTLE, 8, settle window length in clk cycles (minimum 4).
- CW, 8, width of the hazard counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a full sweep; ignored while busy.
- f  input  1  CUT output; asynchronous to clk.
- x  output  N  CUT input vector (registered).
- busy  output  1  sweep in progress.
- step_valid  output  1  one-cycle pulse at the end of each step's window.
- f_out  output  1  settled, synchronized f value; valid with step_valid.
- hazard  output  1  one-cycle pulse with step_valid when the step showed a hazard.
- hazard_x  output  N  x value of the most recent hazard step.
- hazard_count  output  CW  hazards seen in the current sweep; saturates at 2^CW-1.
- done  output  1  one-cycle pulse when the sweep ends.

Behaviour:
- Reset (asynchronous, any time, including mid-sweep):
  - State goes to IDLE.
  - x, busy, step_valid, f_out, hazard, hazard_x, hazard_count and done all go to 0.
  - Synchronizer flops and the window counter clear.
- f passes through a 2-flop synchronizer to give fs. Transition counting uses fs against its previous value fs_d.
- IDLE: busy=0.
  - start=1 → INIT.
  - On the same edge: x<=0, hazard_count<=0, hazard_x<=0.
- INIT: busy=1. Wait SETTLE cycles with no hazard check.
  - Baseline f_prev <= fs.
  - step index k<=0 → APPLY.
- APPLY (1 cycle): x <= gray((k+1) mod 2^N), where gray(i)=i^(i>>1). Exactly one bit of x changes.
  - Clear the transition counter tc.
  - Go to WIN.
- WIN (SETTLE cycles):
  - On each cycle where fs != fs_d, tc increments; tc saturates at 3, 2 bits.
  - On the last cycle go to EVAL.
- EVAL (1 cycle): step_valid=1, f_out=fs.
  - expected = (fs != f_prev) ? 1 : 0.
  - If tc > expected:
    - hazard=1, hazard_x<=x, hazard_count increments (saturating).
    - Static hazard: expected=0 and tc≥2. Dynamic hazard: expected=1 and tc≥3.
  - f_prev<=fs.
  - If k = 2^N-1 → FIN; otherwise k<=k+1 → APPLY.
- FIN (1 cycle): done=1, busy=0 → IDLE. x stays at 0, because the final Gray step returns to code 0.
- Step latency is 1+SETTLE+1 cycles. A full sweep takes 1+SETTLE+2^N·(SETTLE+2)+1 cycles from start to done.
- start asserted in FIN or IDLE on the same edge as done is accepted only in IDLE.
- Sequence for N=2: x = 01,11,10,00 (from 00).
- Glitches narrower than one clk period may be missed. This is a documented limitation, not an error.

Optional Feature:
- Macro AZAR_SEQ_STOP_ON_HAZARD_EN.
- Defined:
  - The first hazard ends the sweep. The FSM goes EVAL→FIN instead of APPLY.
  - done pulses and x holds the hazarding vector, not 0.
  - hazard_count is at most 1.
- Undefined: the sweep always covers all 2^N steps.

Decomposition:
- Package azar_pkg holds:
  - the state enum (IDLE, INIT, APPLY, WIN, EVAL, FIN);
  - the gray() function;
  - constant SETTLE_MIN=4.
- One sub-module, azar_edge_cnt: the 2-flop synchronizer plus the saturating 2-bit transition counter, with clear input. Outputs are fs and tc.

Test Plan:
- Reset mid-sweep: assert reset during WIN of step 2 → all outputs 0 immediately, x=0, busy=0. A new start then runs a full sweep normally.
- Clean CUT: N=2, f=x[0]&x[1] modelled glitch-free → 4 step_valid pulses; f_out=0,1,0,0; hazard never set; hazard_count=0; done exactly 1+8+4·10+1=50 cycles after start.
- Static-1 hazard: bench model pulses f low for 2 clk cycles when x goes 11→10, final f=1 → hazard on step 3, hazard_x=10, hazard_count=1, f_out=1.
- Dynamic hazard: model makes f go 0→1→0→1 on 01→11 → hazard on step 2, hazard_x=11. Plain 0→1 steps are not flagged.
- Start while busy: pulse start during WIN → ignored; sweep count and done timing are unchanged.
- With AZAR_SEQ_STOP_ON_HAZARD_EN: same stimulus as the static-1 hazard test → done after step 3, x holds 10, hazard_count=1. Without the macro, the sweep continues and ends with x=00.
